pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//  Program-counter stage feeding the instruction memory read address (13-bit word index into 8192-entry Imem).
//  Holds the PC register and selects the next PC: sequential, branch, jump, or jump-register redirects.
//  Supports stall and halt, and tells the instruction memory and decode logic when the PC is valid.
//  Replaces the free-running PC register/adder pair with one synchronous, resettable unit.
// PARAMETERS
//  AW        13      PC width in words; Imem depth = 2**AW
//  RESET_PC  0       word address loaded on reset, exits BOOT at this value
// PORTS
//  clk            in   1    single clock; all state updates on rising edge
//  rst_n          in   1    synchronous reset, active low
//  stall          in   1    hold PC this cycle (downstream not ready)
//  branch_taken   in   1    conditional branch resolved taken
//  branch_imm     in   16   signed word offset, relative to pc+1
//  jump           in   1    absolute jump (J/JAL)
//  jump_target    in   26   instruction index field
//  jr             in   1    jump register
//  jr_addr        in   32   byte address from register file
//  halt           in   1    stop fetching; sticky until reset
//  pc             out  AW   current fetch address -> Imem read address
//  pc_plus        out  AW   pc+1 mod 2**AW (combinational; link value for JAL)
//  fetch_valid    out  1    pc is a live fetch address this cycle
//  halted         out  1    unit in HALT state
//  pc_fault       out  1    illegal jr target (only with PC_FAULT_EN; otherwise tied 0)
// BEHAVIOUR
//  Clock and reset:
//  - Synchronous active-low reset, sampled on the rising edge of clk.
//  - Reset values: state=BOOT, pc=RESET_PC, fetch_valid=0, halted=0, pc_fault=0.
//  - Reset wins over every other input, including mid-redirect and while in HALT.
//  States:
//  - BOOT: fetch_valid=0, pc held. Next edge -> RUN unconditionally.
//  - RUN: fetch_valid=1. pc updates every edge per priority below.
//  - HALT: fetch_valid=0, halted=1, pc frozen. Leaves only on reset.
//  Next-PC priority in RUN (highest first):
//  - halt -> HALT with pc unchanged.
//  - fault (PC_FAULT_EN only) -> HALT with pc unchanged.
//  - stall -> pc unchanged. Redirect inputs are dropped; the driver re-presents them after the stall.
//  - jr -> jr_addr[AW+1:2].
//  - jump -> jump_target[AW-1:0].
//  - branch_taken -> pc + 1 + sext(branch_imm).
//  - otherwise -> pc + 1.
//  Arithmetic and boundaries:
//  - All arithmetic is mod 2**AW: 8191+1 -> 0, and a negative branch below 0 wraps.
//  - Simultaneous jr, jump and branch_taken: the highest-priority one is taken and the rest are ignored.
//  - Latency: a redirect sampled at edge N appears on pc after edge N, so Imem reads the target at edge N+1.
//  - halt and stall together: halt wins.
//  - halt while in BOOT is ignored; only RUN evaluates halt.
// CONFIGURATION
//  PC_FAULT_EN defined:
//  - A jr is a fault if jr_addr[1:0]!=0 or any jr_addr[31:AW+2] bit is set, and the jr is not masked by stall or halt.
//  - On a fault: pc_fault=1 and halted=1 from the next edge, state=HALT, pc keeps its pre-jr value. pc_fault is sticky until reset.
//  PC_FAULT_EN undefined:
//  - pc_fault is tied 0, no checking is done, and jr_addr bits outside [AW+1:2] are silently discarded.
// TESTING
//  - rst_n=0 for 2 edges, then 1 -> one BOOT cycle (valid=0, pc=0), then pc 0,1,2,3 with valid=1.
//  - pc=5, branch_taken=1, imm=16'hFFFE -> next pc=4. pc=5, imm=3 -> next pc=9.
//  - pc=8191 sequential -> pc=0. pc=2, imm=16'hFFF0 -> pc=8179.
//  - jr=1, jump=1 (target=100), branch=1 together at pc=10, jr_addr=32'h40 -> pc=16. Drop jr -> next redirect gives pc=100.
//  - stall=1 for 3 edges at pc=7 with jump asserted -> pc stays 7. Stall released -> pc=8.
//  - halt at pc=20 -> halted=1, valid=0, pc=20 held for 10 edges. Then rst_n=0 -> BOOT, pc=0.
//  - PC_FAULT_EN: jr_addr=32'h42 -> pc_fault=1, pc unchanged. jr_addr=32'h8000 -> fault. Without the macro, 32'h42 -> pc=16.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - program-counter stage driving the instruction memory read address
//
// Holds the PC and selects the next PC with this priority: halt, fault, stall,
// jump-register, jump, taken branch, sequential. All PC arithmetic wraps mod 2**AW.
// Optional feature macro: PC_FAULT_EN enables the illegal jump-register target check.
//
// Ports:
//   clk           clock; all state changes on the rising edge
//   rst_n         synchronous reset, active low
//   stall         hold pc this cycle; redirects presented with it are dropped
//   branch_taken  conditional branch resolved taken
//   branch_imm    signed word offset relative to pc+1
//   jump          absolute jump, target from jump_target[AW-1:0]
//   jump_target   instruction index field
//   jr            jump register, target from jr_addr[AW+1:2]
//   jr_addr       byte address from the register file
//   halt          stop fetching; sticky until reset
//   pc            current fetch address (Imem read address)
//   pc_plus       pc+1 mod 2**AW, link value for JAL
//   fetch_valid   pc is a live fetch address this cycle
//   halted        unit is in HALT
//   pc_fault      illegal jr target seen (always 0 without PC_FAULT_EN)

module pc_fetch_unit #(
   parameter int            AW       = 13,
   parameter logic [AW-1:0] RESET_PC = '0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          stall,
   input  logic          branch_taken,
   input  logic [15:0]   branch_imm,
   input  logic          jump,
   input  logic [25:0]   jump_target,
   input  logic          jr,
   input  logic [31:0]   jr_addr,
   input  logic          halt,
   output logic [AW-1:0] pc,
   output logic [AW-1:0] pc_plus,
   output logic          fetch_valid,
   output logic          halted,
   output logic          pc_fault
);

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] pc_q, pc_d;
   logic          fault_q, fault_d;

   logic [31:0]   imm_ext;
   logic [AW-1:0] branch_tgt;
   logic          jr_bad;

   // Sign-extend to 32 bits and keep only AW bits; the add then wraps mod 2**AW
   // for both forward and backward offsets.
   assign imm_ext    = {{16{branch_imm[15]}}, branch_imm};
   assign pc_plus    = pc_q + 1'b1;
   assign branch_tgt = pc_plus + imm_ext[AW-1:0];

`ifdef PC_FAULT_EN
   // Misaligned byte address, or an address beyond the Imem word range.
   assign jr_bad = (jr_addr[1:0] != 2'b00) || (|(jr_addr >> (AW + 2)));
`else
   assign jr_bad = 1'b0;
`endif

   // Address/immediate bits outside the used fields are intentionally dropped.
   logic unused_bits;
   assign unused_bits = &{1'b0, imm_ext[31:AW], jump_target[25:AW],
                          jr_addr[31:AW+2], jr_addr[1:0]};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_BOOT;
         pc_q    <= RESET_PC;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         fault_q <= fault_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      fault_d = fault_q;
      case (state_q)
         ST_BOOT: begin
            // halt is not evaluated here; BOOT always advances to RUN.
            state_d = ST_RUN;
         end
         ST_RUN: begin
            if (halt) begin
               state_d = ST_HALT;
            end else if (jr && !stall && jr_bad) begin
               state_d = ST_HALT;
               fault_d = 1'b1;
            end else if (stall) begin
               pc_d = pc_q;
            end else if (jr) begin
               pc_d = jr_addr[AW+1:2];
            end else if (jump) begin
               pc_d = jump_target[AW-1:0];
            end else if (branch_taken) begin
               pc_d = branch_tgt;
            end else begin
               pc_d = pc_plus;
            end
         end
         ST_HALT: begin
            state_d = ST_HALT;
         end
         default: begin
            state_d = ST_BOOT;
         end
      endcase
   end

   assign pc          = pc_q;
   assign fetch_valid = (state_q == ST_RUN);
   assign halted      = (state_q == ST_HALT);

`ifdef PC_FAULT_EN
   assign pc_fault = fault_q;
`else
   assign pc_fault = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - directed self-checking bench for pc_fetch_unit

module tb_pc_fetch_unit;

   localparam int AW = 13;

   logic          clk;
   logic          rst_n;
   logic          stall;
   logic          branch_taken;
   logic [15:0]   branch_imm;
   logic          jump;
   logic [25:0]   jump_target;
   logic          jr;
   logic [31:0]   jr_addr;
   logic          halt;
   logic [AW-1:0] pc;
   logic [AW-1:0] pc_plus;
   logic          fetch_valid;
   logic          halted;
   logic          pc_fault;

   int checks   = 0;
   int failures = 0;

   pc_fetch_unit #(.AW(AW), .RESET_PC('0)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .stall        (stall),
      .branch_taken (branch_taken),
      .branch_imm   (branch_imm),
      .jump         (jump),
      .jump_target  (jump_target),
      .jr           (jr),
      .jr_addr      (jr_addr),
      .halt         (halt),
      .pc           (pc),
      .pc_plus      (pc_plus),
      .fetch_valid  (fetch_valid),
      .halted       (halted),
      .pc_fault     (pc_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic clear_inputs();
      stall = 0; branch_taken = 0; branch_imm = '0; jump = 0;
      jump_target = '0; jr = 0; jr_addr = '0; halt = 0;
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Reset for two edges, release, step through BOOT into RUN at pc=0.
   task automatic start_run();
      clear_inputs();
      rst_n = 0;
      cyc(); cyc();
      rst_n = 1;
      cyc();
   endtask

   task automatic goto_pc(input logic [AW-1:0] p);
      jump = 1; jump_target = 26'(p);
      cyc();
      jump = 0; jump_target = '0;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst_n = 0;
      cyc(); cyc();
      checks++;
      if (pc !== 13'd0 || fetch_valid !== 1'b0 || halted !== 1'b0 || pc_fault !== 1'b0) begin
         failures++;
         $display("FAIL reset_state: pc=%0d valid=%b halted=%b fault=%b, want 0 0 0 0",
                  pc, fetch_valid, halted, pc_fault);
      end
      rst_n = 1;
      checks++;
      if (pc !== 13'd0 || fetch_valid !== 1'b0) begin
         failures++;
         $display("FAIL boot_cycle: pc=%0d valid=%b, want 0 0", pc, fetch_valid);
      end
      for (int i = 0; i < 4; i++) begin
         cyc();
         checks++;
         if (pc !== 13'(i) || fetch_valid !== 1'b1) begin
            failures++;
            $display("FAIL seq_after_boot[%0d]: pc=%0d valid=%b, want %0d 1", i, pc, fetch_valid, i);
         end
      end
   endtask

   task automatic test_branch();
      start_run();
      goto_pc(13'd5);
      branch_taken = 1; branch_imm = 16'hFFFE;
      cyc();
      checks++;
      if (pc !== 13'd4) begin
         failures++;
         $display("FAIL branch_back: pc=%0d want 4", pc);
      end
      branch_taken = 0;
      goto_pc(13'd5);
      branch_taken = 1; branch_imm = 16'd3;
      cyc();
      checks++;
      if (pc !== 13'd9) begin
         failures++;
         $display("FAIL branch_fwd: pc=%0d want 9", pc);
      end
      branch_taken = 0; branch_imm = '0;
   endtask

   task automatic test_wrap();
      start_run();
      goto_pc(13'd8191);
      checks++;
      if (pc_plus !== 13'd0) begin
         failures++;
         $display("FAIL pc_plus_wrap: pc_plus=%0d want 0", pc_plus);
      end
      cyc();
      checks++;
      if (pc !== 13'd0) begin
         failures++;
         $display("FAIL seq_wrap: pc=%0d want 0", pc);
      end
      goto_pc(13'd2);
      branch_taken = 1; branch_imm = 16'hFFF0;
      cyc();
      checks++;
      if (pc !== 13'd8179) begin
         failures++;
         $display("FAIL branch_wrap: pc=%0d want 8179", pc);
      end
      branch_taken = 0; branch_imm = '0;
   endtask

   task automatic test_priority();
      start_run();
      goto_pc(13'd10);
      jr = 1; jr_addr = 32'h40;
      jump = 1; jump_target = 26'd100;
      branch_taken = 1; branch_imm = 16'd3;
      cyc();
      checks++;
      if (pc !== 13'd16) begin
         failures++;
         $display("FAIL prio_jr: pc=%0d want 16", pc);
      end
      jr = 0;
      cyc();
      checks++;
      if (pc !== 13'd100) begin
         failures++;
         $display("FAIL prio_jump: pc=%0d want 100", pc);
      end
      jump = 0;
      cyc();
      checks++;
      if (pc !== 13'd104) begin
         failures++;
         $display("FAIL prio_branch: pc=%0d want 104", pc);
      end
      branch_taken = 0; branch_imm = '0; jump_target = '0; jr_addr = '0;
   endtask

   task automatic test_stall();
      start_run();
      goto_pc(13'd7);
      stall = 1; jump = 1; jump_target = 26'd50;
      for (int i = 0; i < 3; i++) begin
         cyc();
         checks++;
         if (pc !== 13'd7 || fetch_valid !== 1'b1) begin
            failures++;
            $display("FAIL stall_hold[%0d]: pc=%0d valid=%b want 7 1", i, pc, fetch_valid);
         end
      end
      stall = 0; jump = 0; jump_target = '0;
      cyc();
      checks++;
      if (pc !== 13'd8) begin
         failures++;
         $display("FAIL stall_release: pc=%0d want 8", pc);
      end
   endtask

   task automatic test_halt();
      start_run();
      goto_pc(13'd20);
      halt = 1; stall = 1;
      cyc();
      halt = 0; stall = 0;
      checks++;
      if (halted !== 1'b1 || fetch_valid !== 1'b0 || pc !== 13'd20) begin
         failures++;
         $display("FAIL halt_enter: halted=%b valid=%b pc=%0d want 1 0 20", halted, fetch_valid, pc);
      end
      jump = 1; jump_target = 26'd300;
      for (int i = 0; i < 10; i++) begin
         cyc();
         checks++;
         if (halted !== 1'b1 || fetch_valid !== 1'b0 || pc !== 13'd20) begin
            failures++;
            $display("FAIL halt_hold[%0d]: halted=%b valid=%b pc=%0d want 1 0 20",
                     i, halted, fetch_valid, pc);
         end
      end
      rst_n = 0;
      cyc();
      checks++;
      if (pc !== 13'd0 || halted !== 1'b0 || fetch_valid !== 1'b0) begin
         failures++;
         $display("FAIL halt_reset: pc=%0d halted=%b valid=%b want 0 0 0", pc, halted, fetch_valid);
      end
      rst_n = 1; jump = 0; jump_target = '0;
   endtask

   task automatic test_boot_halt();
      clear_inputs();
      rst_n = 0;
      cyc(); cyc();
      rst_n = 1; halt = 1;
      cyc();
      checks++;
      if (fetch_valid !== 1'b1 || halted !== 1'b0 || pc !== 13'd0) begin
         failures++;
         $display("FAIL boot_ignores_halt: valid=%b halted=%b pc=%0d want 1 0 0", fetch_valid, halted, pc);
      end
      cyc();
      halt = 0;
      checks++;
      if (halted !== 1'b1 || pc !== 13'd0) begin
         failures++;
         $display("FAIL run_halt: halted=%b pc=%0d want 1 0", halted, pc);
      end
   endtask

   task automatic test_reset_mid_redirect();
      start_run();
      goto_pc(13'd33);
      rst_n = 0; jr = 1; jr_addr = 32'h100;
      cyc();
      checks++;
      if (pc !== 13'd0 || fetch_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_redirect: pc=%0d valid=%b want 0 0", pc, fetch_valid);
      end
      rst_n = 1; jr = 0; jr_addr = '0;
   endtask

   task automatic test_jr_fault();
      logic [AW-1:0] exp_pc;
      logic          exp_fault;
      // Stalled bad jr is masked in either build.
      start_run();
      goto_pc(13'd10);
      jr = 1; jr_addr = 32'h42; stall = 1;
      cyc();
      stall = 0; jr = 0;
      checks++;
      if (pc !== 13'd10 || pc_fault !== 1'b0 || halted !== 1'b0) begin
         failures++;
         $display("FAIL jr_masked_by_stall: pc=%0d fault=%b halted=%b want 10 0 0", pc, pc_fault, halted);
      end
      jr = 1; jr_addr = 32'h42;
      cyc();
      jr = 0;
`ifdef PC_FAULT_EN
      exp_pc = 13'd10; exp_fault = 1'b1;
`else
      exp_pc = 13'd16; exp_fault = 1'b0;
`endif
      checks++;
      if (pc !== exp_pc || pc_fault !== exp_fault || halted !== exp_fault) begin
         failures++;
         $display("FAIL jr_misaligned: pc=%0d fault=%b halted=%b want %0d %b %b",
                  pc, pc_fault, halted, exp_pc, exp_fault, exp_fault);
      end
      cyc(); cyc();
`ifdef PC_FAULT_EN
      exp_pc = 13'd10;
`else
      exp_pc = 13'd18;
`endif
      checks++;
      if (pc !== exp_pc || pc_fault !== exp_fault) begin
         failures++;
         $display("FAIL jr_fault_sticky: pc=%0d fault=%b want %0d %b", pc, pc_fault, exp_pc, exp_fault);
      end
      start_run();
      goto_pc(13'd10);
      jr = 1; jr_addr = 32'h8000;
      cyc();
      jr = 0; jr_addr = '0;
`ifdef PC_FAULT_EN
      exp_pc = 13'd10;
`else
      exp_pc = 13'd0;
`endif
      checks++;
      if (pc !== exp_pc || pc_fault !== exp_fault) begin
         failures++;
         $display("FAIL jr_out_of_range: pc=%0d fault=%b want %0d %b", pc, pc_fault, exp_pc, exp_fault);
      end
   endtask

   initial begin
      rst_n = 0;
      clear_inputs();
      test_reset();
      test_branch();
      test_wrap();
      test_priority();
      test_stall();
      test_halt();
      test_boot_halt();
      test_reset_mid_redirect();
      test_jr_fault();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
